// File: rtl/spi_controller.sv
// SPI initiator, mode 0, MSB first, write-only 16-bit frames:
//   frame = {1'b1 (write), addr[6:0], data[7:0]}
// A one-deep command buffer lets the next command queue while a frame shifts.
//
// Parameters:
//   CLK_DIV  clk cycles per SCLK half-period (4..255; the peripheral needs
//            3-flop synchronisation margin, so smaller values are illegal)
//   CS_IDLE  minimum clk cycles nCS stays high between frames (1..255)
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake, accepted on valid & ready
//   cmd_addr, cmd_data   register address and write data
//   busy                 frame loaded into shifter until end of its nCS gap
//   done                 one-cycle pulse as nCS rises at frame end
//   SCLK, COPI, nCS      SPI bus (SCLK idles low, nCS active low)
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int CS_IDLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       SCLK,
    output logic       COPI,
    output logic       nCS
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_IDLE);

    state_t      state, state_nxt;
    logic [7:0]  div_cnt, div_nxt;
    logic [4:0]  bit_cnt, bit_nxt;
    logic [7:0]  gap_cnt, gap_nxt;
    logic [15:0] shreg, shreg_nxt;
    logic [15:0] buf_frame;
    logic        buf_full, full_nxt;
    logic        sclk_nxt, copi_nxt, ncs_nxt, busy_nxt, done_nxt;

    logic div_end, gap_end, last_bit, accept, load;

    assign div_end  = (div_cnt == DIV_LAST);
    // GAP runs CS_IDLE+1 cycles: CS_IDLE of idle time plus the cycle that
    // decides between restarting and returning to IDLE.
    assign gap_end  = (gap_cnt == GAP_LAST);
    // bit_cnt indexes the bit currently on COPI; 15 means the last high phase.
    assign last_bit = (bit_cnt == 5'd15);
    assign accept   = cmd_valid & cmd_ready;
    assign load     = buf_full & ((state == IDLE) | ((state == GAP) & gap_end));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (buf_full) state_nxt = SETUP;
            SETUP:   if (div_end) state_nxt = SHIFT;
            SHIFT:   if (div_end && SCLK && last_bit) state_nxt = HOLD;
            HOLD:    if (div_end) state_nxt = GAP;
            GAP:     if (gap_end) state_nxt = buf_full ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values (all outputs are registered below)
    always_comb begin
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        shreg_nxt = shreg;
        sclk_nxt  = SCLK;
        copi_nxt  = COPI;
        ncs_nxt   = nCS;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            SETUP: begin
                div_nxt = div_end ? 8'd0 : div_cnt + 8'd1;
                if (div_end) sclk_nxt = 1'b1;
            end
            SHIFT: begin
                div_nxt = div_end ? 8'd0 : div_cnt + 8'd1;
                if (div_end) begin
                    sclk_nxt = ~SCLK;
                    // Falling edge: present the next bit together with SCLK low
                    if (SCLK) begin
                        if (last_bit) begin
                            copi_nxt = 1'b0;
                        end else begin
                            copi_nxt  = shreg[14];
                            shreg_nxt = shreg << 1;
                            bit_nxt   = bit_cnt + 5'd1;
                        end
                    end
                end
            end
            HOLD: begin
                div_nxt = div_end ? 8'd0 : div_cnt + 8'd1;
                if (div_end) begin
                    ncs_nxt  = 1'b1;
                    done_nxt = 1'b1;
                    gap_nxt  = 8'd0;
                end
            end
            GAP: begin
                gap_nxt = gap_end ? 8'd0 : gap_cnt + 8'd1;
                if (gap_end && !buf_full) busy_nxt = 1'b0;
            end
            default: ;
        endcase
        // Frame start, from IDLE or directly out of GAP
        if (load) begin
            shreg_nxt = buf_frame;
            ncs_nxt   = 1'b0;
            copi_nxt  = buf_frame[15];
            busy_nxt  = 1'b1;
            div_nxt   = 8'd0;
            bit_nxt   = 5'd0;
        end
    end

    // Accept and load are mutually exclusive (accept needs empty, load full)
    always_comb begin
        full_nxt = buf_full;
        if (load)        full_nxt = 1'b0;
        else if (accept) full_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= 8'd0;
            bit_cnt   <= 5'd0;
            gap_cnt   <= 8'd0;
            shreg     <= 16'd0;
            buf_frame <= 16'd0;
            buf_full  <= 1'b0;
            cmd_ready <= 1'b1;
            SCLK      <= 1'b0;
            COPI      <= 1'b0;
            nCS       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            gap_cnt   <= gap_nxt;
            shreg     <= shreg_nxt;
            buf_full  <= full_nxt;
            cmd_ready <= ~full_nxt;
            SCLK      <= sclk_nxt;
            COPI      <= copi_nxt;
            nCS       <= ncs_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            if (accept) buf_frame <= {1'b1, cmd_addr, cmd_data};
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: one instance with default timing
// (CLK_DIV=4, CS_IDLE=4) and one at the slow corner (CLK_DIV=255, CS_IDLE=1).
module tb_spi_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v   [2];
    logic [6:0] a   [2];
    logic [7:0] d   [2];
    logic       rdy [2];
    logic       bsy [2];
    logic       dn  [2];
    logic       sck [2];
    logic       sdo [2];
    logic       cs  [2];

    spi_controller #(.CLK_DIV(4), .CS_IDLE(4)) u_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v[0]), .cmd_addr(a[0]),
        .cmd_data(d[0]), .cmd_ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
        .SCLK(sck[0]), .COPI(sdo[0]), .nCS(cs[0]));

    spi_controller #(.CLK_DIV(255), .CS_IDLE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v[1]), .cmd_addr(a[1]),
        .cmd_data(d[1]), .cmd_ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
        .SCLK(sck[1]), .COPI(sdo[1]), .nCS(cs[1]));

    // Bus monitor state, one slot per instance
    int          dv [2];
    int          low_cnt [2], hi_cnt [2], rises [2], frames [2];
    int          dones [2], viol [2], since [2];
    logic [15:0] bits [2];
    logic        prev_cs [2], prev_sck [2], prev_sdo [2];
    logic [15:0] flog  [2][8];
    int          flow  [2][8], frise [2][8], fgap [2][8];

    int n_cmp, n_fail;

    task automatic mon(input int i);
        if (!rst_n) begin
            low_cnt[i] = 0; hi_cnt[i] = 0; rises[i] = 0; bits[i] = '0;
            since[i] = 0; prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; prev_sdo[i] = 1'b0;
        end else begin
            if (dn[i]) dones[i]++;
            if (sck[i] && cs[i]) viol[i]++;                 // SCLK high with nCS high
            if (sdo[i] != prev_sdo[i]) begin
                if (sck[i] && prev_sck[i]) viol[i]++;       // COPI moved during high phase
                since[i] = 0;
            end else begin
                since[i]++;
            end
            if (!cs[i]) begin
                if (prev_cs[i]) begin
                    fgap[i][frames[i] % 8] = hi_cnt[i];
                    low_cnt[i] = 0; rises[i] = 0; bits[i] = '0;
                end
                low_cnt[i]++;
                if (sck[i] && !prev_sck[i]) begin
                    rises[i]++;
                    bits[i] = {bits[i][14:0], sdo[i]};
                    if (since[i] < dv[i]) viol[i]++;        // setup before rising edge
                end
            end else begin
                if (!prev_cs[i]) begin
                    flog[i][frames[i] % 8]  = bits[i];
                    flow[i][frames[i] % 8]  = low_cnt[i];
                    frise[i][frames[i] % 8] = rises[i];
                    frames[i]++;
                    hi_cnt[i] = 0;
                end
                hi_cnt[i]++;
            end
            prev_cs[i] = cs[i]; prev_sck[i] = sck[i]; prev_sdo[i] = sdo[i];
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [6:0] ad, input logic [7:0] da);
        int n = 0;
        v[i] = 1'b1; a[i] = ad; d[i] = da;
        while (!rdy[i] && n < 20000) begin tick(); n++; end
        if (n >= 20000) check("send_timeout", 0, 1);
        tick();
        v[i] = 1'b0;
    endtask

    task automatic wait_frames(input int i, input int tgt, input int bound);
        int n = 0;
        while (frames[i] < tgt && n < bound) begin tick(); n++; end
        if (frames[i] < tgt) check("frame_timeout", frames[i], tgt);
    endtask

    task automatic wait_cs_low(input int i, input int bound);
        int n = 0;
        while (cs[i] && n < bound) begin tick(); n++; end
        if (cs[i]) check("cs_low_timeout", cs[i], 0);
    endtask

    initial begin
        int f0, dc, n, bl;
        n_cmp = 0; n_fail = 0;
        dv[0] = 4; dv[1] = 255;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; a[i] = '0; d[i] = '0;
            frames[i] = 0; dones[i] = 0; viol[i] = 0; hi_cnt[i] = 0;
        end
        rst_n = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_ncs",   cs[0],  1);
        check("rst_sclk",  sck[0], 0);
        check("rst_copi",  sdo[0], 0);
        check("rst_busy",  bsy[0], 0);
        check("rst_done",  dn[0],  0);
        check("rst_ready", rdy[0], 1);
        tick(); rst_n = 1'b1; tick();

        // Single write 0x00/0xA5
        send(0, 7'h00, 8'hA5);
        n = 0;
        while (!dn[0] && n < 500) begin tick(); n++; end
        check("single_done_seen", dn[0], 1);
        check("single_bits",  flog[0][0], 16'h80A5);
        check("single_low",   flow[0][0], 132);
        check("single_rises", frise[0][0], 16);
        check("single_dones", dones[0], 1);
        n = 0;
        do begin tick(); n++; end while (bsy[0] && n < 100);
        check("single_busy_drop", n, 5);

        // Back-to-back: second command queued while the first shifts
        f0 = frames[0]; dc = dones[0];
        send(0, 7'h01, 8'h3C);
        wait_cs_low(0, 100);
        send(0, 7'h02, 8'hFF);
        n = 0; bl = 0;
        while (frames[0] < f0 + 2 && n < 2000) begin
            tick(); n++;
            if (!bsy[0]) bl++;
        end
        check("b2b_frames", frames[0], f0 + 2);
        check("b2b_bits0",  flog[0][f0 % 8], 16'h813C);
        check("b2b_bits1",  flog[0][(f0 + 1) % 8], 16'h82FF);
        check("b2b_gap",    fgap[0][(f0 + 1) % 8], 5);
        check("b2b_busy_low_cycles", bl, 0);
        check("b2b_dones",  dones[0], dc + 2);
        n = 0;
        while (bsy[0] && n < 100) begin tick(); n++; end

        // Held request while the buffer is full
        f0 = frames[0];
        send(0, 7'h10, 8'h11);
        send(0, 7'h12, 8'h34);
        check("held_ready_low", rdy[0], 0);
        v[0] = 1'b1; a[0] = 7'h13; d[0] = 8'h56;
        n = 0;
        while (!rdy[0] && n < 2000) begin tick(); n++; end
        check("held_waited", (n > 100), 1);
        tick();
        v[0] = 1'b0;
        check("held_accepted", rdy[0], 0);
        wait_frames(0, f0 + 3, 3000);
        repeat (300) tick();
        check("held_no_dup", frames[0], f0 + 3);
        check("held_bits0", flog[0][f0 % 8], 16'h9011);
        check("held_bits1", flog[0][(f0 + 1) % 8], 16'h9234);
        check("held_bits2", flog[0][(f0 + 2) % 8], 16'h9356);

        // Reset at rising edge 7 of a frame
        f0 = frames[0];
        send(0, 7'h03, 8'h77);
        n = 0;
        while (rises[0] != 7 && n < 500) begin tick(); n++; end
        check("rst7_reached", rises[0], 7);
        dc = dones[0];
        rst_n = 1'b0;
        #1;
        check("rst7_ncs",   cs[0],  1);
        check("rst7_sclk",  sck[0], 0);
        check("rst7_copi",  sdo[0], 0);
        check("rst7_busy",  bsy[0], 0);
        check("rst7_ready", rdy[0], 1);
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check("rst7_no_done",  dones[0], dc);
        check("rst7_no_frame", frames[0], f0);
        send(0, 7'h04, 8'h5A);
        wait_frames(0, f0 + 1, 500);
        check("rst7_new_bits",  flog[0][f0 % 8], 16'h845A);
        check("rst7_new_low",   flow[0][f0 % 8], 132);
        check("rst7_new_rises", frise[0][f0 % 8], 16);

        // Address/data extremes
        f0 = frames[0];
        send(0, 7'h7F, 8'h00);
        send(0, 7'h04, 8'h81);
        wait_frames(0, f0 + 2, 1000);
        check("ext_bits_7f", flog[0][f0 % 8], 16'hFF00);
        check("ext_bits_04", flog[0][(f0 + 1) % 8], 16'h8481);

        // Slow corner: CLK_DIV=255, CS_IDLE=1
        f0 = frames[1];
        send(1, 7'h55, 8'hC3);
        wait_cs_low(1, 100);
        send(1, 7'h2A, 8'h3C);
        wait_frames(1, f0 + 2, 20000);
        check("slow_bits0",  flog[1][f0 % 8], 16'hD5C3);
        check("slow_low0",   flow[1][f0 % 8], 8415);
        check("slow_rises0", frise[1][f0 % 8], 16);
        check("slow_bits1",  flog[1][(f0 + 1) % 8], 16'hAA3C);
        check("slow_low1",   flow[1][(f0 + 1) % 8], 8415);
        check("slow_gap",    fgap[1][(f0 + 1) % 8], 2);

        // Bus timing rules observed throughout
        check("bus_rules_a", viol[0], 0);
        check("bus_rules_b", viol[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
